sva_stim_gen: RTL and testbench
===============================

Name: sva_stim_gen

Overview:
- Stimulus transmitter for the sequence-checker FSMs: drives `gclk`, `grst`, `a` and `b` into a checker of the form "!a, then (!a && !b)[*0:$], then b".
- Runs in the `sys_clk` domain. Derives the user clock by division and plays commanded patterns beat by beat.
- Reports the verdict the checker must give for the thread started at each pattern's head beat.
- Instanced in the bench next to the checker. Its expected-verdict outputs feed the scoreboard.

Parameters:
- DIV, 4: `sys_clk` cycles per `gclk` half-period; legal range 2..255.
- LEN_W, 8: width of the command wait-length field.
- GRST_BEATS, 2: number of `gclk` periods that `grst` is held high after `start`.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins the user-reset phase
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when `cmd_valid && cmd_ready`
- cmd_kind  in  2  0 = PASS, 1 = FAIL_S1, 2 = FAIL_S0, 3 = treated as PASS
- cmd_len  in  LEN_W  number of wait beats (!a, !b) after the head beat
- cmd_rand  in  1  use a random wait length (only when the optional feature is compiled in)
- gclk  out  1  generated user clock
- grst  out  1  user reset, active high
- a  out  1  driven stimulus
- b  out  1  driven stimulus
- busy  out  1  high whenever state is not IDLE or READY
- exp_valid  out  1  one-cycle pulse with the expected verdict
- exp_succ  out  1  expected verdict is success (valid with `exp_valid`)
- exp_fail  out  1  expected verdict is failure (valid with `exp_valid`)

Behaviour:
- Reset (`sys_rst_n` = 0, async): every output is 0, state = IDLE, divider = 0.
- Clock generation:
  - The divider counts 0..DIV-1 every `sys_clk` cycle from reset, in all states.
  - At DIV-1 the divider wraps and `gclk` toggles. Period = 2*DIV `sys_clk` cycles.
  - "Fall event" = the `sys_clk` edge on which `gclk` goes 1→0.
  - A beat = one `gclk` period, from fall event to fall event.
  - `a`, `b` and `grst` change only on fall events, so they are stable around every `gclk` rising edge.
- State IDLE:
  - `a` = 0, `b` = 0, `grst` = 0.
  - `start` → state RST, latched immediately.
  - `cmd_valid` is ignored.
- State RST:
  - `grst` = 1 from the next fall event, held for GRST_BEATS beats.
  - At the fall event ending the last beat, `grst` drops and state → READY.
  - `start` is ignored in RST.
- State READY:
  - `cmd_ready` = 1, `a` = 0, `b` = 0 (idle beats are "!a, !b").
  - On handshake, latch `kind` and `len`; `cmd_ready` → 0 the next cycle.
  - The pattern begins at the next fall event.
  - `start` in READY → RST (re-reset).
- State HEAD (1 beat):
  - FAIL_S0: `a` = 1, `b` = 0.
  - Otherwise: `a` = 0, `b` = 0.
  - FAIL_S0 ends after this beat → go to VERDICT.
- State WAIT (`len` beats): `a` = 0, `b` = 0.
  - A down-counter loads `len` and decrements each fall event.
  - `len` = 0 skips WAIT entirely.
- State TAIL (1 beat):
  - PASS: `a` = 0, `b` = 1.
  - FAIL_S1: `a` = 1, `b` = 0.
- State VERDICT (1 `sys_clk` cycle):
  - On the fall event that ends the final pattern beat, pulse `exp_valid` for one cycle.
  - PASS gives `exp_succ` = 1; FAIL_S0 and FAIL_S1 give `exp_fail` = 1.
  - Then → READY, and `a`/`b` return to 0 on that same fall event.
  - Total beats: 1 for FAIL_S0, otherwise `len`+2.
  - A new handshake in the same READY cycle starts HEAD at the following fall event, so there is at most one idle beat between patterns.
- Mid-pattern `start`: abort without pulsing `exp_valid`, `a` = `b` = 0, → RST.
- `sys_rst_n` low mid-pattern: immediate return to reset values.
- `cmd_valid` with `cmd_ready` low: no effect; the command is held by the sender.

Optional Feature:
- Macro: `SVA_STIM_LFSR_EN`.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every `sys_clk` cycle.
  - A handshake with `cmd_rand` = 1 latches LFSR[LEN_W-1:0] as `len` instead of `cmd_len`.
- Undefined: `cmd_rand` is ignored and `cmd_len` is always used. No LFSR logic is present.

Test Plan:
- DIV=4: release reset, observe `gclk` → toggles every 4 `sys_clk` cycles (period 8) from the first wrap; `a`=`b`=`grst`=0.
- Pulse `start` → `grst` high for exactly 2 beats (16 cycles), aligned to fall events; then `cmd_ready`=1.
- PASS, `len`=3 → beats `a`/`b` = 00,00,00,00,01; `exp_valid` with `exp_succ`=1 at the end of beat 5; `cmd_ready` back to 1.
- FAIL_S1, `len`=0 → beats 00,10; `exp_fail`=1 after 2 beats. FAIL_S0 → beat 10 only; `exp_fail`=1 after 1 beat.
- `start` pulsed during WAIT of PASS `len`=10 → no `exp_valid`, `a`=`b`=0, `grst` high for 2 beats, then READY.
- With `SVA_STIM_LFSR_EN` and `cmd_rand`=1 → WAIT length equals LFSR[7:0] at handshake (reference model of seed 16'hACE1); without the macro, the same stimulus uses `cmd_len`.

Source files
------------

// File: rtl/sva_stim_gen.sv
// Stimulus generator for "!a ##1 (!a && !b)[*0:$] ##1 b" checkers: divides sys_clk into gclk,
// plays commanded patterns on a/b and reports the expected verdict. Optional: SVA_STIM_LFSR_EN.
module sva_stim_gen #(
   parameter int unsigned DIV        = 4,
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned GRST_BEATS = 2
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             start,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_kind,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_rand,
   output logic             gclk,
   output logic             grst,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             exp_valid,
   output logic             exp_succ,
   output logic             exp_fail
);

   localparam int unsigned DIV_W = 8;
   localparam int unsigned GB_W  = (GRST_BEATS > 2) ? $clog2(GRST_BEATS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_READY, S_HEAD, S_WAIT, S_TAIL, S_VERDICT
   } state_t;

   typedef enum logic [1:0] {
      K_PASS = 2'd0, K_FAIL_S1 = 2'd1, K_FAIL_S0 = 2'd2, K_PASS_ALT = 2'd3
   } kind_t;

   state_t             state_q, state_d;
   kind_t              kind_q, kind_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [GB_W-1:0]    gcnt_q, gcnt_d;
   logic               gclk_q, gclk_d;
   logic               grst_q, grst_d;
   logic               a_q, a_d;
   logic               b_q, b_d;
   logic               pend_q, pend_d;
   logic               exp_valid_q, exp_valid_d;
   logic               exp_succ_q, exp_succ_d;
   logic               exp_fail_q, exp_fail_d;
   logic               wrap, fall, hs;
   logic [LEN_W-1:0]   len_sel;

`ifdef SVA_STIM_LFSR_EN
   // Fibonacci form, taps 16,14,13,11 (shift right, feedback into bit 15); requires LEN_W <= 16.
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      len_sel = cmd_rand ? lfsr_q[LEN_W-1:0] : cmd_len;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) lfsr_q <= 16'hACE1;
      else            lfsr_q <= lfsr_d;
   end
`else
   logic unused_cmd_rand;

   always_comb begin
      len_sel         = cmd_len;
      unused_cmd_rand = cmd_rand;
   end
`endif

   always_comb begin
      wrap      = (div_q == DIV_W'(DIV - 1));
      fall      = wrap && gclk_q;
      div_d     = wrap ? '0 : div_q + 1'b1;
      gclk_d    = wrap ? ~gclk_q : gclk_q;
      cmd_ready = (state_q == S_READY) && !pend_q;
      busy      = (state_q != S_IDLE) && (state_q != S_READY);
      hs        = cmd_valid && cmd_ready;

      state_d     = state_q;
      kind_d      = kind_q;
      cnt_d       = cnt_q;
      gcnt_d      = gcnt_q;
      grst_d      = grst_q;
      a_d         = a_q;
      b_d         = b_q;
      pend_d      = pend_q;
      exp_valid_d = 1'b0;
      exp_succ_d  = 1'b0;
      exp_fail_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            a_d    = 1'b0;
            b_d    = 1'b0;
            grst_d = 1'b0;
            if (start) state_d = S_RST;
         end
         S_RST: begin
            if (fall) begin
               if (!grst_q) begin
                  grst_d = 1'b1;
                  gcnt_d = '0;
               end else if (gcnt_q == GB_W'(GRST_BEATS - 1)) begin
                  grst_d  = 1'b0;
                  pend_d  = 1'b0;
                  state_d = S_READY;
               end else begin
                  gcnt_d = gcnt_q + 1'b1;
               end
            end
         end
         S_READY: begin
            if (start) begin
               pend_d  = 1'b0;
               state_d = S_RST;
            end else if (hs) begin
               // A command taken on a fall edge waits for the following fall to start.
               pend_d = 1'b1;
               kind_d = kind_t'(cmd_kind);
               cnt_d  = len_sel;
            end else if (fall && pend_q) begin
               pend_d  = 1'b0;
               state_d = S_HEAD;
               a_d     = (kind_q == K_FAIL_S0);
               b_d     = 1'b0;
            end
         end
         S_HEAD: begin
            if (fall) begin
               if (kind_q == K_FAIL_S0) begin
                  state_d     = S_VERDICT;
                  a_d         = 1'b0;
                  b_d         = 1'b0;
                  exp_valid_d = 1'b1;
                  exp_fail_d  = 1'b1;
               end else if (cnt_q == '0) begin
                  state_d = S_TAIL;
                  a_d     = (kind_q == K_FAIL_S1);
                  b_d     = (kind_q != K_FAIL_S1);
               end else begin
                  state_d = S_WAIT;
                  a_d     = 1'b0;
                  b_d     = 1'b0;
               end
            end
         end
         S_WAIT: begin
            if (fall) begin
               if (cnt_q <= LEN_W'(1)) begin
                  state_d = S_TAIL;
                  a_d     = (kind_q == K_FAIL_S1);
                  b_d     = (kind_q != K_FAIL_S1);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_TAIL: begin
            if (fall) begin
               state_d     = S_VERDICT;
               a_d         = 1'b0;
               b_d         = 1'b0;
               exp_valid_d = 1'b1;
               exp_succ_d  = (kind_q != K_FAIL_S1);
               exp_fail_d  = (kind_q == K_FAIL_S1);
            end
         end
         S_VERDICT: state_d = S_READY;
         default:   state_d = S_IDLE;
      endcase

      // Abort overrides any in-flight pattern, including its verdict.
      if (start && busy && (state_q != S_RST)) begin
         state_d     = S_RST;
         a_d         = 1'b0;
         b_d         = 1'b0;
         grst_d      = 1'b0;
         exp_valid_d = 1'b0;
         exp_succ_d  = 1'b0;
         exp_fail_d  = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         kind_q      <= K_PASS;
         div_q       <= '0;
         cnt_q       <= '0;
         gcnt_q      <= '0;
         gclk_q      <= 1'b0;
         grst_q      <= 1'b0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         pend_q      <= 1'b0;
         exp_valid_q <= 1'b0;
         exp_succ_q  <= 1'b0;
         exp_fail_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         gcnt_q      <= gcnt_d;
         gclk_q      <= gclk_d;
         grst_q      <= grst_d;
         a_q         <= a_d;
         b_q         <= b_d;
         pend_q      <= pend_d;
         exp_valid_q <= exp_valid_d;
         exp_succ_q  <= exp_succ_d;
         exp_fail_q  <= exp_fail_d;
      end
   end

   always_comb begin
      gclk      = gclk_q;
      grst      = grst_q;
      a         = a_q;
      b         = b_q;
      exp_valid = exp_valid_q;
      exp_succ  = exp_succ_q;
      exp_fail  = exp_fail_q;
   end

endmodule

// File: tb/tb_sva_stim_gen.sv
// Directed, table-driven bench for sva_stim_gen (DIV=4, GRST_BEATS=2); honours SVA_STIM_LFSR_EN.
module tb_sva_stim_gen;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_kind = 2'd0;
   logic [7:0] cmd_len = 8'd0;
   logic       cmd_rand = 1'b0;
   logic       gclk, grst, a, b, busy, exp_valid, exp_succ, exp_fail;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0] cap [0:299];

   always #5 sys_clk = ~sys_clk;

   sva_stim_gen #(.DIV(4), .LEN_W(8), .GRST_BEATS(2)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
      .cmd_len(cmd_len), .cmd_rand(cmd_rand), .gclk(gclk), .grst(grst),
      .a(a), .b(b), .busy(busy), .exp_valid(exp_valid),
      .exp_succ(exp_succ), .exp_fail(exp_fail)
   );

`ifdef SVA_STIM_LFSR_EN
   logic [15:0] m_lfsr;
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) m_lfsr <= 16'hACE1;
      else            m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end
`endif

   typedef struct {
      logic [1:0] kind;
      logic [7:0] len;
      int         beats;
      logic [1:0] head;
      logic [1:0] tail;
      logic       succ;
   } vec_t;

   vec_t vecs [0:5];

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic send_cmd(input logic [1:0] k, input logic [7:0] l, input logic r,
                           output logic [7:0] len_used);
      int n = 0;
      cmd_kind  = k;
      cmd_len   = l;
      cmd_rand  = r;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 5000) begin
         @(negedge sys_clk);
         n++;
      end
      check("hs_ready", int'(cmd_ready), 1);
`ifdef SVA_STIM_LFSR_EN
      len_used = r ? m_lfsr[7:0] : l;
`else
      len_used = l;
`endif
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      check("ready_drop", int'(cmd_ready), 0);
   endtask

   task automatic collect(output int beats, output int idle, output logic got,
                          output logic succ, output logic fail);
      logic prev_g = gclk;
      beats = 0; idle = 0; got = 1'b0; succ = 1'b0; fail = 1'b0;
      for (int n = 0; n < 4000 && !got; n++) begin
         @(negedge sys_clk);
         if (gclk && !prev_g) begin
            if (busy) begin
               if (beats < 300) cap[beats] = {a, b};
               beats++;
            end else if (beats == 0) begin
               idle++;
            end
         end
         prev_g = gclk;
         if (exp_valid) begin
            got = 1'b1; succ = exp_succ; fail = exp_fail;
         end
      end
      check("verdict_seen", int'(got), 1);
   endtask

   task automatic run_vec(input string tag, input logic [1:0] k, input logic [7:0] l,
                          input logic r, input int exp_idle, input vec_t v);
      int beats, idle, bad_beats, exp_beats;
      logic got, succ, fail;
      logic [1:0] want;
      logic [7:0] len_used;
      send_cmd(k, l, r, len_used);
      collect(beats, idle, got, succ, fail);
      exp_beats = (v.beats < 0) ? int'(len_used) + 2 : v.beats;
      check({tag, "_beats"}, beats, exp_beats);
      bad_beats = 0;
      for (int j = 0; j < beats && j < 300; j++) begin
         if (j == 0)                   want = v.head;
         else if (j == exp_beats - 1)  want = v.tail;
         else                          want = 2'b00;
         if (cap[j] !== want) bad_beats++;
      end
      check({tag, "_pattern_errs"}, bad_beats, 0);
      check({tag, "_succ"}, int'(succ), int'(v.succ));
      check({tag, "_fail"}, int'(fail), int'(!v.succ));
      if (exp_idle >= 0) check({tag, "_idle_beats"}, idle, exp_idle);
      @(negedge sys_clk);
      check({tag, "_valid_one_cycle"}, int'(exp_valid), 0);
      check({tag, "_ready_back"}, int'(cmd_ready), 1);
   endtask

   // From a start pulse: grst must rise on a fall edge, stay 16 cycles, then READY.
   task automatic reset_phase(input string tag);
      logic prev_g = gclk;
      int n = 0, hi = 0, verd = 0;
      logic aligned = 1'b0;
      while (!grst && n < 200) begin
         @(negedge sys_clk);
         if (exp_valid) verd++;
         if (grst) aligned = prev_g && !gclk;
         prev_g = gclk;
         n++;
      end
      check({tag, "_grst_aligned"}, int'(aligned), 1);
      while (grst && n < 400) begin
         hi++;
         if (exp_valid || a || b) verd++;
         @(negedge sys_clk);
         n++;
      end
      check({tag, "_grst_cycles"}, hi, 16);
      check({tag, "_ready_after_rst"}, int'(cmd_ready), 1);
      check({tag, "_quiet_during_rst"}, verd, 0);
   endtask

   initial begin
      vec_t v;
      int n, lo, hi, noise;
      logic [7:0] dummy;

      vecs[0] = '{kind: 2'd0, len: 8'd3, beats: 5, head: 2'b00, tail: 2'b01, succ: 1'b1};
      vecs[1] = '{kind: 2'd1, len: 8'd0, beats: 2, head: 2'b00, tail: 2'b10, succ: 1'b0};
      vecs[2] = '{kind: 2'd2, len: 8'd5, beats: 1, head: 2'b10, tail: 2'b10, succ: 1'b0};
      vecs[3] = '{kind: 2'd3, len: 8'd1, beats: 3, head: 2'b00, tail: 2'b01, succ: 1'b1};
      vecs[4] = '{kind: 2'd0, len: 8'd0, beats: 2, head: 2'b00, tail: 2'b01, succ: 1'b1};
      vecs[5] = '{kind: 2'd1, len: 8'd2, beats: 4, head: 2'b00, tail: 2'b10, succ: 1'b0};

      repeat (3) @(negedge sys_clk);
      check("reset_outputs",
            int'({gclk, grst, a, b, busy, cmd_ready, exp_valid, exp_succ, exp_fail}), 0);

      cmd_valid = 1'b1;
      sys_rst_n = 1'b1;
      noise = 0;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
         if (a || b || grst || cmd_ready || busy) noise++;
      end while (!gclk && n < 50);
      check("first_gclk_rise", n, 4);
      hi = 0;
      do begin
         @(negedge sys_clk);
         hi++;
         if (a || b || grst || cmd_ready || busy) noise++;
      end while (gclk && hi < 50);
      lo = 0;
      do begin
         @(negedge sys_clk);
         lo++;
         if (a || b || grst || cmd_ready || busy) noise++;
      end while (!gclk && lo < 50);
      check("gclk_high_half", hi, 4);
      check("gclk_period", hi + lo, 8);
      check("idle_ignores_cmd", noise, 0);
      cmd_valid = 1'b0;

      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      check("rst_busy", int'(busy), 1);
      reset_phase("init");

      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         run_vec($sformatf("vec%0d", i), v.kind, v.len, 1'b0, (i == 0) ? -1 : 1, v);
      end

      // Abort in the middle of a long wait.
      send_cmd(2'd0, 8'd10, 1'b0, dummy);
      n = 0;
      lo = 0;
      while (lo < 4 && n < 500) begin
         @(negedge sys_clk);
         if (gclk && busy && (dut.div_q == 8'd0)) lo++;
         n++;
      end
      check("abort_reached_wait", lo, 4);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      check("abort_ab_zero", int'({a, b}), 0);
      check("abort_no_verdict", int'(exp_valid), 0);
      reset_phase("abort");

      v = '{kind: 2'd0, len: 8'd6, beats: 8, head: 2'b00, tail: 2'b01, succ: 1'b1};
`ifdef SVA_STIM_LFSR_EN
      v.beats = -1;
`endif
      run_vec("rand", 2'd0, 8'd6, 1'b1, -1, v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
